// File: rtl/bmem_burst_tx.sv
`default_nettype none
// ============================================================================
// Module   : bmem_burst_tx
// Purpose  : Issues line reads to bmem and serializes dirty lines into beats.
// Revision : 1.0
// ============================================================================
module bmem_burst_tx #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  input  logic                  dfp_rresp,
  output logic                  dfp_wresp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready
);

  localparam int c_beats = LINE_WIDTH / BEAT_WIDTH;
  localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_offs  = $clog2(LINE_WIDTH / 8);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_R = 3'd1,
    S_RWAIT   = 3'd2,
    S_ISSUE_W = 3'd3,
    S_WBURST  = 3'd4,
    S_WDONE   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_unused_offs;

  assign w_req_addr    = {dfp_addr[ADDR_WIDTH-1:c_offs], c_offs'(0)};
  // Byte offset within the line is intentionally discarded.
  assign w_unused_offs = &{1'b0, dfp_addr[c_offs-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (dfp_write) begin
            r_addr <= w_req_addr;
            r_line <= dfp_wdata;
          end else if (dfp_read) begin
            r_addr <= w_req_addr;
          end
        end
        S_ISSUE_W: if (bmem_ready) r_cnt <= c_cnt_w'(1);
        S_WBURST:  r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dfp_write)     w_next = S_ISSUE_W;
        else if (dfp_read) w_next = S_ISSUE_R;
      end
      S_ISSUE_R: if (bmem_ready) w_next = S_RWAIT;
      S_RWAIT:   if (dfp_rresp)  w_next = S_IDLE;
      S_ISSUE_W: if (bmem_ready) w_next = S_WBURST;
      // Once beat 0 is accepted the remaining beats stream without stalling.
      S_WBURST:  if (r_cnt == c_last_beat) w_next = S_WDONE;
      S_WDONE:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    bmem_addr  = '0;
    dfp_wresp  = 1'b0;
    busy       = (r_state != S_IDLE);
    if (r_state != S_IDLE) bmem_addr = r_addr;
    case (r_state)
      S_ISSUE_R: bmem_read = 1'b1;
      S_ISSUE_W: begin
        bmem_write = 1'b1;
        bmem_wdata = r_line[BEAT_WIDTH-1:0];
      end
      S_WBURST: begin
        bmem_write = 1'b1;
        bmem_wdata = r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH];
      end
      S_WDONE: dfp_wresp = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/bmem_burst_tx.md
# bmem_burst_tx

Memory-side transmitter sitting between the cache's downstream port and the banked memory (bmem). Issues line read requests and serializes a 256-bit dirty line into back-to-back 64-bit write beats. It is the outbound complement of the cacheline adapter, which assembles incoming 64-bit read beats into a 256-bit line. The transmitter owns bmem_addr, bmem_read, bmem_write and bmem_wdata. It tracks an outstanding read until the adapter reports the line assembled.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cache line width in bits
- BEAT_WIDTH, 64, bmem data bus width; BEATS = LINE_WIDTH/BEAT_WIDTH (4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- dfp_addr  in  ADDR_WIDTH  request address (any byte within line)
- dfp_read  in  1  line read request, level, held until dfp_rresp
- dfp_write  in  1  line write request, level, held until dfp_wresp
- dfp_wdata  in  LINE_WIDTH  line to write, beat 0 = bits [63:0]
- dfp_rresp  in  1  one-cycle pulse from cacheline adapter: read line assembled
- dfp_wresp  out  1  one-cycle pulse: all write beats sent
- busy  out  1  high in any state other than IDLE
- bmem_addr  out  ADDR_WIDTH  line-aligned address, low 5 bits zero
- bmem_read  out  1  read command strobe
- bmem_write  out  1  write beat strobe
- bmem_wdata  out  BEAT_WIDTH  write beat data
- bmem_ready  in  1  memory can accept a new command this cycle

## Operation
- States: IDLE, ISSUE_R, RWAIT, ISSUE_W, WBURST, WDONE.
- IDLE: if dfp_write, latch {dfp_addr[31:5],5'b0} and dfp_wdata, go ISSUE_W. Else if dfp_read, latch aligned address, go ISSUE_R. Write has priority when both are high.
- ISSUE_R: drive bmem_read=1 and bmem_addr. If bmem_ready=1, the command is accepted; go RWAIT. Else hold with outputs unchanged.
- RWAIT: all bmem strobes 0. On dfp_rresp go IDLE.
- ISSUE_W: drive bmem_write=1, bmem_addr, bmem_wdata = line[63:0]. If bmem_ready=1, set beat counter to 1 and go WBURST. Else hold.
- WBURST: bmem_write=1, bmem_wdata = line[64*cnt +: 64], counter increments every cycle regardless of bmem_ready. After beat BEATS-1, go WDONE.
- WDONE: dfp_wresp=1 for exactly this cycle, strobes 0, go IDLE.
- bmem_addr is the latched address, held constant across all beats. It is 0 in IDLE.
- bmem_wdata is 0 whenever bmem_write=0.
- Requester deasserts its request in the cycle after the response. In the IDLE cycle following WDONE or RWAIT exit, a still-high request is treated as new.
- dfp_rresp outside RWAIT is ignored.
- Latched address and data are not re-sampled after IDLE. Changes on dfp_* mid-transaction have no effect.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, line/address registers 0. bmem_read, bmem_write, bmem_wdata, bmem_addr, dfp_wresp, busy all 0.
- Reset mid-burst aborts with no further beats. Strobes drop without waiting for a clock edge.
- Request sampled in IDLE at edge E. ISSUE_* is visible from E, i.e. the strobe appears the cycle after the request is first seen.
- bmem outputs are decoded combinationally from registered state, counter and latched data. There is no combinational path from dfp_* or bmem_ready to bmem_*.
- Write with bmem_ready=1 at cycle T in ISSUE_W: beats 0..3 in cycles T..T+3, dfp_wresp at T+4, IDLE at T+5. Minimum request-to-wresp latency is 5 cycles.
- Each cycle bmem_ready=0 in ISSUE_* adds one cycle.
- Read: bmem_read is high in every ISSUE_R cycle and falls the cycle after acceptance.

## Test plan
- Reset then idle: rst pulse asynchronously mid-cycle -> all outputs 0 immediately. busy=0 for 10 idle cycles.
- Single write: dfp_addr=0x1ECEB01C, dfp_wdata=0x…0004_…0003_…0002_…0001 (beat k = k+1), bmem_ready=1 -> bmem_addr=0x1ECEB000 for 4 consecutive cycles, wdata 1,2,3,4, then dfp_wresp for one cycle.
- Write with backpressure: bmem_ready=0 for 3 cycles then 1 -> ISSUE_W held 3 extra cycles, then beat 0 and 3 contiguous beats. Dropping bmem_ready mid-burst does not stall the beats.
- Read: dfp_read, addr=0x1ECEB044, bmem_ready=1 -> single bmem_read pulse with addr 0x1ECEB040, busy stays 1. dfp_rresp 12 cycles later -> IDLE next cycle. A second dfp_rresp while idle is ignored.
- Simultaneous dfp_read and dfp_write -> write burst first, wresp. Read issued after returning to IDLE with dfp_read still high.
- Reset asserted at beat 2 of a write -> bmem_write=0 immediately, no wresp. A new write after reset starts again at beat 0.
